jt1943_rom_sched: RTL and testbench
===================================

JT1943_ROM_SCHED -- requirements
Module: jt1943_rom_sched

Interface
REQ-001 SHALL have parameter CHAR_OFFSET, default 22'h00000, SDRAM word offset of char ROM.
REQ-002 SHALL have parameter SCR_OFFSET, default 22'h04000, SDRAM word offset of scroll ROM.
REQ-003 SHALL have parameter OBJ_OFFSET, default 22'h14000, SDRAM word offset of object ROM.
REQ-004 SHALL have ports:
- clk  in  1  system clock, 48 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- char_cs  in  1  char layer wants data.
- char_addr  in  14  char ROM word address.
- char_data  out  16  char ROM word.
- char_ok  out  1  char_data valid for current char_addr.
- scr_cs, scr_addr[14:0], scr_data[15:0], scr_ok  as char, scroll layer.
- obj_cs, obj_addr[15:0], obj_data[15:0], obj_ok  as char, object layer.
- sdram_req  out  1  request to SDRAM controller.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  one-cycle pulse: request accepted.
- data_rdy  in  1  one-cycle pulse: data_read valid.
- data_read  in  16  SDRAM read word.

Function
REQ-005 Each requester SHALL hold a one-entry cache: tag (its address width), data (16), valid.
REQ-006 <x>_ok SHALL equal <x>_cs AND valid AND (tag == <x>_addr), combinationally; <x>_data SHALL be the cached data.
REQ-007 A requester is pending when <x>_cs=1 and <x>_ok=0 and it is not the requester in flight.
REQ-008 FSM states IDLE, WAIT_ACK, WAIT_DATA; exactly one transaction in flight at most.
REQ-009 IDLE: if any requester pending, select one, latch its address and id, set sdram_req=1, go WAIT_ACK next cycle.
REQ-010 Arbitration: char pending always wins; otherwise scr and obj alternate, the one not granted last winning a tie.
REQ-011 sdram_addr SHALL be offset + zero-extended latched address, modulo 2^22, registered, stable while sdram_req=1.
REQ-012 WAIT_ACK: on sdram_ack, drop sdram_req next cycle and go WAIT_DATA; if data_rdy is also 1 that cycle, complete as REQ-013 and go IDLE.
REQ-013 On data_rdy in WAIT_DATA: write data_read to the granted requester's cache with tag = latched address, valid=1; go IDLE.
REQ-014 Latency: <x>_ok SHALL rise the cycle after data_rdy if <x>_addr still equals the latched address.
REQ-015 Address change mid-flight: transaction SHALL complete and fill the cache with the old tag; ok stays 0; new request issued from IDLE.
REQ-016 cs drop mid-flight: transaction SHALL complete and fill the cache normally.
REQ-017 data_rdy or sdram_ack in IDLE SHALL be ignored.
REQ-018 New grant SHALL not be issued on the same cycle as a completion; minimum one IDLE cycle between transactions.

Reset
REQ-019 While rst_n=0 at a clk edge: state=IDLE, sdram_req=0, sdram_addr=0, all valid=0, all data=0, tags=0, last-granted=obj.
REQ-020 Reset mid-transaction SHALL abandon it; a following data_rdy SHALL be ignored.
REQ-021 All <x>_ok SHALL be 0 the cycle after reset asserts.

Structure
REQ-022 Package jt1943_rom_pkg SHALL hold the FSM state type, requester-id type (CHAR, SCR, OBJ) and default offset constants.
REQ-023 One sub-module jt1943_rom_slot (cache entry, tag compare, ok/data outputs), parameterised by address width, instantiated three times.

Verification
REQ-024 char_cs=1, char_addr=14'h0123, ack after 3 cycles, data_rdy 5 cycles later with 16'hBEEF -> sdram_addr=22'h000123, char_ok=1, char_data=16'hBEEF the cycle after data_rdy.
REQ-025 char, scr, obj all pending in IDLE -> grant order char, scr, obj; obj_addr=16'h0010 yields sdram_addr=22'h014010.
REQ-026 char_addr changes 14'h0001->14'h0002 in WAIT_DATA -> char_ok stays 0, second request for 22'h000002 issued, then char_ok=1.
REQ-027 sdram_ack and data_rdy in same cycle -> cache filled, FSM back in IDLE, sdram_req low next cycle.
REQ-028 rst_n=0 in WAIT_DATA, then data_rdy -> sdram_req=0, all ok=0, no cache written.
REQ-029 scr and obj continuously pending, char idle -> grants strictly alternate scr/obj over 10 transactions.

Source files
------------

// File: rtl/jt1943_rom_pkg.sv
// rtl/jt1943_rom_pkg.sv - shared types and default ROM offsets for the ROM scheduler
package jt1943_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ID_CHAR = 2'd0,
    ID_SCR  = 2'd1,
    ID_OBJ  = 2'd2
  } req_id_t;

  localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00000;
  localparam logic [21:0] DEF_SCR_OFFSET  = 22'h04000;
  localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h14000;

  // SDRAM word address of a layer-local word; wraps modulo 2^22.
  function automatic logic [21:0] rom_addr(input logic [21:0] offset, input logic [15:0] addr);
    return offset + {6'd0, addr};
  endfunction

endpackage

// File: rtl/jt1943_rom_slot.sv
// rtl/jt1943_rom_slot.sv - one-entry ROM word cache with tag compare
module jt1943_rom_slot #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [15:0]   wr_data,
  output logic [15:0]   data,
  output logic          ok
);

  logic          valid;
  logic [AW-1:0] tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  assign ok = cs & valid & (tag == addr);

endmodule

// File: rtl/jt1943_rom_sched.sv
// rtl/jt1943_rom_sched.sv - arbitrates char/scroll/object ROM reads onto one SDRAM port
module jt1943_rom_sched import jt1943_rom_pkg::*; #(
  parameter logic [21:0] CHAR_OFFSET = DEF_CHAR_OFFSET,
  parameter logic [21:0] SCR_OFFSET  = DEF_SCR_OFFSET,
  parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_cs,
  input  logic [13:0] char_addr,
  output logic [15:0] char_data,
  output logic        char_ok,
  input  logic        scr_cs,
  input  logic [14:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [15:0] obj_addr,
  output logic [15:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [15:0] data_read
);

  state_t      state;
  req_id_t     cur_id;
  logic [15:0] lat_addr;
  logic        last_obj;

  logic        char_pend, scr_pend, obj_pend;
  logic        gnt_valid;
  req_id_t     gnt_id;
  logic [15:0] gnt_addr;
  logic [21:0] gnt_offset;
  logic        done;

  // Grants are only issued from IDLE, where nothing is in flight.
  assign char_pend = char_cs & ~char_ok;
  assign scr_pend  = scr_cs & ~scr_ok;
  assign obj_pend  = obj_cs & ~obj_ok;

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_id     = ID_CHAR;
    gnt_addr   = 16'd0;
    gnt_offset = CHAR_OFFSET;
    if (char_pend) begin
      gnt_valid  = 1'b1;
      gnt_id     = ID_CHAR;
      gnt_addr   = {2'd0, char_addr};
      gnt_offset = CHAR_OFFSET;
    end else if (scr_pend && (!obj_pend || last_obj)) begin
      gnt_valid  = 1'b1;
      gnt_id     = ID_SCR;
      gnt_addr   = {1'b0, scr_addr};
      gnt_offset = SCR_OFFSET;
    end else if (obj_pend) begin
      gnt_valid  = 1'b1;
      gnt_id     = ID_OBJ;
      gnt_addr   = obj_addr;
      gnt_offset = OBJ_OFFSET;
    end
  end

  assign done = data_rdy && ((state == ST_WAIT_DATA) ||
                             (state == ST_WAIT_ACK && sdram_ack));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_id     <= ID_CHAR;
      lat_addr   <= 16'd0;
      last_obj   <= 1'b1;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            cur_id     <= gnt_id;
            lat_addr   <= gnt_addr;
            sdram_req  <= 1'b1;
            sdram_addr <= rom_addr(gnt_offset, gnt_addr);
            state      <= ST_WAIT_ACK;
            if (gnt_id == ID_SCR) last_obj <= 1'b0;
            if (gnt_id == ID_OBJ) last_obj <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= data_rdy ? ST_IDLE : ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (data_rdy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  jt1943_rom_slot #(.AW(14)) u_char (
    .clk(clk), .rst_n(rst_n), .cs(char_cs), .addr(char_addr),
    .wr(done && cur_id == ID_CHAR), .wr_tag(lat_addr[13:0]), .wr_data(data_read),
    .data(char_data), .ok(char_ok)
  );

  jt1943_rom_slot #(.AW(15)) u_scr (
    .clk(clk), .rst_n(rst_n), .cs(scr_cs), .addr(scr_addr),
    .wr(done && cur_id == ID_SCR), .wr_tag(lat_addr[14:0]), .wr_data(data_read),
    .data(scr_data), .ok(scr_ok)
  );

  jt1943_rom_slot #(.AW(16)) u_obj (
    .clk(clk), .rst_n(rst_n), .cs(obj_cs), .addr(obj_addr),
    .wr(done && cur_id == ID_OBJ), .wr_tag(lat_addr), .wr_data(data_read),
    .data(obj_data), .ok(obj_ok)
  );

endmodule

// File: tb/tb_jt1943_rom_sched.sv
// tb/tb_jt1943_rom_sched.sv - directed vector bench for the ROM scheduler
module tb_jt1943_rom_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_cs, scr_cs, obj_cs;
  logic [13:0] char_addr;
  logic [14:0] scr_addr;
  logic [15:0] obj_addr;
  logic [15:0] char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack, data_rdy;
  logic [15:0] data_read;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jt1943_rom_sched dut (
    .clk(clk), .rst_n(rst_n),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read)
  );

  typedef struct {
    int          id;
    logic [15:0] addr;
    int          ack_dly;
    int          rdy_dly;
    logic [15:0] data;
    logic [21:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_ok(input int id);
    case (id)
      0: return char_ok;
      1: return scr_ok;
      default: return obj_ok;
    endcase
  endfunction

  function automatic logic [15:0] get_data(input int id);
    case (id)
      0: return char_data;
      1: return scr_data;
      default: return obj_data;
    endcase
  endfunction

  task automatic set_req(input int id, input logic cs, input logic [15:0] addr);
    case (id)
      0: begin char_cs = cs; char_addr = addr[13:0]; end
      1: begin scr_cs = cs; scr_addr = addr[14:0]; end
      default: begin obj_cs = cs; obj_addr = addr; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for a request, then play the SDRAM side; returns the observed address.
  task automatic do_txn(input int ack_dly, input int rdy_dly, input logic [15:0] d,
                        output logic [21:0] got);
    int n = 0;
    while (!sdram_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, sdram_req}, 32'd1);
    got = sdram_addr;
    repeat (ack_dly - 1) @(negedge clk);
    chk("addr_stable", {10'd0, sdram_addr}, {10'd0, got});
    sdram_ack = 1'b1;
    if (rdy_dly == 0) begin
      data_rdy = 1'b1;
      data_read = d;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    if (rdy_dly > 0) begin
      chk("req_drop", {31'd0, sdram_req}, 32'd0);
      repeat (rdy_dly - 1) @(negedge clk);
      data_rdy = 1'b1;
      data_read = d;
      @(negedge clk);
      data_rdy = 1'b0;
    end
    chk("idle_gap", {31'd0, sdram_req}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [21:0] got;
    logic [21:0] expa;
    rst_n = 1'b0;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    char_addr = '0; scr_addr = '0; obj_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;

    vecs[0] = '{0, 16'h0123, 3, 5, 16'hBEEF, 22'h000123};
    vecs[1] = '{1, 16'h7FFF, 1, 1, 16'h1234, 22'h00BFFF};
    vecs[2] = '{2, 16'hFFFF, 2, 3, 16'hCAFE, 22'h023FFF};
    vecs[3] = '{2, 16'h0010, 1, 2, 16'h5A5A, 22'h014010};
    vecs[4] = '{0, 16'h3FFF, 1, 0, 16'h0F0F, 22'h003FFF};
    vecs[5] = '{1, 16'h0000, 4, 1, 16'hA5A5, 22'h004000};

    // Reset state: cs high on address 0 must not hit an unfilled cache.
    char_cs = 1'b1; scr_cs = 1'b1; obj_cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst_oks", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
    chk("rst_data", {char_data, obj_data}, 32'd0);
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].addr);
      #1;
      chk($sformatf("v%0d_miss", i), {31'd0, get_ok(vecs[i].id)}, 32'd0);
      do_txn(vecs[i].ack_dly, vecs[i].rdy_dly, vecs[i].data, got);
      chk($sformatf("v%0d_addr", i), {10'd0, got}, {10'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_ok", i), {31'd0, get_ok(vecs[i].id)}, 32'd1);
      chk($sformatf("v%0d_data", i), {16'd0, get_data(vecs[i].id)}, {16'd0, vecs[i].data});
      set_req(vecs[i].id, 1'b0, vecs[i].addr);
      #1;
      chk($sformatf("v%0d_cs_gate", i), {31'd0, get_ok(vecs[i].id)}, 32'd0);
      @(negedge clk);
    end

    // All three pending at once: char, then scr, then obj.
    do_reset();
    char_cs = 1'b1; char_addr = 14'h0005;
    scr_cs = 1'b1; scr_addr = 15'h0006;
    obj_cs = 1'b1; obj_addr = 16'h0010;
    do_txn(1, 1, 16'h1111, got);
    chk("order_char", {10'd0, got}, 32'h000005);
    do_txn(1, 1, 16'h2222, got);
    chk("order_scr", {10'd0, got}, 32'h004006);
    do_txn(1, 1, 16'h3333, got);
    chk("order_obj", {10'd0, got}, 32'h014010);
    chk("order_oks", {29'd0, char_ok, scr_ok, obj_ok}, 32'h7);

    // Address change while waiting for data.
    do_reset();
    char_cs = 1'b1; char_addr = 14'h0001;
    while (!sdram_req) @(negedge clk);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    char_addr = 14'h0002;
    @(negedge clk);
    data_rdy = 1'b1; data_read = 16'h0001;
    @(negedge clk);
    data_rdy = 1'b0;
    chk("chg_ok_low", {31'd0, char_ok}, 32'd0);
    do_txn(1, 1, 16'h0002, got);
    chk("chg_readdr", {10'd0, got}, 32'h000002);
    chk("chg_ok", {31'd0, char_ok}, 32'd1);
    chk("chg_data", {16'd0, char_data}, 32'h0002);

    // Reset while waiting for data; the late data_rdy must be dropped.
    do_reset();
    char_cs = 1'b1; char_addr = 14'h0100;
    while (!sdram_req) @(negedge clk);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_req", {31'd0, sdram_req}, 32'd0);
    chk("mrst_oks", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
    char_cs = 1'b0;
    rst_n = 1'b1;
    data_rdy = 1'b1; data_read = 16'hDEAD;
    @(negedge clk);
    data_rdy = 1'b0;
    char_cs = 1'b1;
    #1;
    chk("mrst_nofill", {31'd0, char_ok}, 32'd0);
    chk("mrst_idle", {31'd0, sdram_req}, 32'd0);

    // scr and obj both continuously pending: strict alternation.
    do_reset();
    scr_cs = 1'b1; scr_addr = 15'h0100;
    obj_cs = 1'b1; obj_addr = 16'h0200;
    for (int k = 0; k < 10; k++) begin
      expa = (k % 2 == 0) ? 22'h004000 + {7'd0, scr_addr} : 22'h014000 + {6'd0, obj_addr};
      do_txn(1, 1, 16'(k), got);
      chk($sformatf("alt%0d", k), {10'd0, got}, {10'd0, expa});
      if (k % 2 == 0) scr_addr = scr_addr + 15'd1;
      else obj_addr = obj_addr + 16'd1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
